// File: rtl/stream_aggregator.sv
// ============================================================================
// Module   : stream_aggregator
// Brief    : N_CH per-channel FIFOs merged round-robin onto one tagged,
//            backpressured output stream. STREAM_AGG_STATS_EN adds STAT_CNT.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_aggregator #(
    parameter int   N_CH  = 4,
    parameter int   WIDTH = 64,
    parameter int   DEPTH = 8,
    localparam int  CW    = $clog2(N_CH)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [N_CH*WIDTH-1:0]   IN_DATA,
    input  logic [N_CH-1:0]         IN_VALID,
    output logic [N_CH-1:0]         IN_READY,
    output logic [WIDTH-1:0]        OUT_DATA,
    output logic [CW-1:0]           OUT_CHAN,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY
`ifdef STREAM_AGG_STATS_EN
    ,
    output logic [N_CH*32-1:0]      STAT_CNT
`endif
);

    localparam int            AW         = $clog2(DEPTH);
    localparam logic [AW:0]   C_FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] out_data_q;
    logic [CW-1:0]    out_chan_q;
    logic             out_valid_q;
    logic [CW-1:0]    ptr_q;
    logic [CW-1:0]    ptr_d;

    logic [N_CH-1:0]  w_nonempty;
    logic [WIDTH-1:0] w_head [N_CH];
    logic             w_load;
    logic             w_gnt_valid;
    logic [CW-1:0]    w_gnt;
    int               w_idx;

    // The output register may take a new word whenever it is empty or being drained.
    assign w_load = ~out_valid_q | OUT_READY;

    generate
        for (genvar c = 0; c < N_CH; c++) begin : g_ch
            logic [WIDTH-1:0] mem_q [DEPTH];
            logic [AW-1:0]    wr_ptr_q;
            logic [AW-1:0]    rd_ptr_q;
            logic [AW:0]      cnt_q;
            logic [AW:0]      cnt_d;
            logic             w_push;
            logic             w_pop;

            assign IN_READY[c]   = (cnt_q != C_FULL_CNT);
            assign w_nonempty[c] = (cnt_q != '0);
            assign w_head[c]     = mem_q[rd_ptr_q];
            assign w_push        = IN_VALID[c] & IN_READY[c];
            assign w_pop         = w_load & w_gnt_valid & (w_gnt == CW'(c));

            always_comb begin
                cnt_d = cnt_q;
                case ({w_push, w_pop})
                    2'b10:   cnt_d = cnt_q + 1'b1;
                    2'b01:   cnt_d = cnt_q - 1'b1;
                    default: cnt_d = cnt_q;
                endcase
            end

            always_ff @(posedge CLK) begin
                if (w_push) begin
                    mem_q[wr_ptr_q] <= IN_DATA[c*WIDTH +: WIDTH];
                end
            end

            always_ff @(posedge CLK) begin
                if (RST) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    cnt_q    <= '0;
                end else begin
                    if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
                    if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    // Descending scan so the lowest offset from ptr_q wins.
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt       = ptr_q;
        w_idx       = 0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            w_idx = int'(ptr_q) + i;
            if (w_idx >= N_CH) w_idx = w_idx - N_CH;
            if (w_nonempty[w_idx]) begin
                w_gnt_valid = 1'b1;
                w_gnt       = CW'(w_idx);
            end
        end
    end

    assign ptr_d = (w_gnt == CW'(N_CH - 1)) ? '0 : w_gnt + 1'b1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            ptr_q       <= '0;
        end else if (w_load) begin
            out_valid_q <= w_gnt_valid;
            if (w_gnt_valid) begin
                out_data_q <= w_head[w_gnt];
                out_chan_q <= w_gnt;
                ptr_q      <= ptr_d;
            end
        end
    end

    assign OUT_VALID = out_valid_q;
    assign OUT_DATA  = out_data_q;
    assign OUT_CHAN  = out_chan_q;

`ifdef STREAM_AGG_STATS_EN
    logic [31:0] stat_q [N_CH];

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int c = 0; c < N_CH; c++) stat_q[c] <= '0;
        end else if (out_valid_q & OUT_READY) begin
            stat_q[out_chan_q] <= stat_q[out_chan_q] + 32'd1;
        end
    end

    generate
        for (genvar c = 0; c < N_CH; c++) begin : g_stat
            assign STAT_CNT[c*32 +: 32] = stat_q[c];
        end
    endgenerate
`endif

endmodule

`default_nettype wire

// File: tb/tb_stream_aggregator.sv
// ============================================================================
// Module   : tb_stream_aggregator
// Brief    : Scoreboard bench for stream_aggregator (per-channel expected queues).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_aggregator;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [255:0] IN_DATA = '0;
    logic [3:0]   IN_VALID = '0;
    logic [3:0]   IN_READY;
    logic [63:0]  OUT_DATA;
    logic [1:0]   OUT_CHAN;
    logic         OUT_VALID;
    logic         OUT_READY = 1'b0;
`ifdef STREAM_AGG_STATS_EN
    logic [127:0] STAT_CNT;
`endif

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q [4][$];

    stream_aggregator #(.N_CH(4), .WIDTH(64), .DEPTH(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_DATA   (IN_DATA),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .OUT_DATA  (OUT_DATA),
        .OUT_CHAN  (OUT_CHAN),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY)
`ifdef STREAM_AGG_STATS_EN
        ,
        .STAT_CNT  (STAT_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    // Scoreboard: inputs and OUT_READY are stable here until the next rising edge.
    always @(negedge CLK) begin
        int ch;
        logic [63:0] exp;
        if (RST) begin
            for (int c = 0; c < 4; c++) exp_q[c].delete();
        end else begin
            if (OUT_VALID && OUT_READY) begin
                ch = int'(OUT_CHAN);
                checks++;
                if (exp_q[ch].size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected chan=%0d got=%h required=no word", ch, OUT_DATA);
                end else begin
                    exp = exp_q[ch].pop_front();
                    if (OUT_DATA !== exp) begin
                        errors++;
                        $display("FAIL sb_data chan=%0d got=%h required=%h", ch, OUT_DATA, exp);
                    end
                end
            end
            for (int c = 0; c < 4; c++) begin
                if (IN_VALID[c] && IN_READY[c]) exp_q[c].push_back(IN_DATA[c*64 +: 64]);
            end
        end
    end

    task automatic reset_dut();
        RST = 1'b1;
        IN_VALID = '0;
        OUT_READY = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        @(negedge CLK);
        checks++;
        if (IN_READY !== 4'b1111) begin errors++; $display("FAIL rst_in_ready got=%b required=1111", IN_READY); end
        checks++;
        if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b required=0", OUT_VALID); end
        checks++;
        if (OUT_DATA !== 64'd0) begin errors++; $display("FAIL rst_out_data got=%h required=0", OUT_DATA); end
        checks++;
        if (OUT_CHAN !== 2'd0) begin errors++; $display("FAIL rst_out_chan got=%0d required=0", OUT_CHAN); end
    endtask

    task automatic test_single_latency();
        @(posedge CLK); #1;
        OUT_READY = 1'b1;
        IN_DATA[2*64 +: 64] = 64'hDEAD_BEEF;
        IN_VALID = 4'b0100;
        @(posedge CLK); #1;                 // edge k: word pushed
        IN_VALID = '0;
        @(negedge CLK);
        checks++;
        if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL lat_early got=%b required=0", OUT_VALID); end
        @(negedge CLK);                     // after edge k+1
        checks++;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== 64'hDEAD_BEEF || OUT_CHAN !== 2'd2) begin
            errors++;
            $display("FAIL lat_word got=%b/%h/%0d required=1/deadbeef/2", OUT_VALID, OUT_DATA, OUT_CHAN);
        end
        @(negedge CLK);                     // after edge k+2
        checks++;
        if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL lat_idle got=%b required=0", OUT_VALID); end
    endtask

    task automatic test_round_robin();
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            IN_VALID = 4'b1111;
            for (int c = 0; c < 4; c++) IN_DATA[c*64 +: 64] = 64'(c*16 + i);
        end
        @(posedge CLK); #1;
        IN_VALID = '0;
        @(posedge CLK); #1;
        OUT_READY = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            checks++;
            if (OUT_VALID !== 1'b1 || OUT_CHAN !== 2'(i % 4) || OUT_DATA !== 64'((i % 4)*16 + i/4)) begin
                errors++;
                $display("FAIL rr_seq idx=%0d got=%b/%0d/%h required=1/%0d/%h",
                         i, OUT_VALID, OUT_CHAN, OUT_DATA, i % 4, (i % 4)*16 + i/4);
            end
        end
        @(negedge CLK);
        checks++;
        if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL rr_end got=%b required=0", OUT_VALID); end
    endtask

    task automatic test_backpressure();
        int n = 0;
        int drained = 0;
        bit held_bad = 0;
        reset_dut();
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(posedge CLK); #1;
            IN_VALID = 4'b0001;
            IN_DATA[63:0] = 64'(n);
            @(negedge CLK);
            if (OUT_VALID && OUT_DATA !== 64'd0) held_bad = 1;
            if (IN_READY[0]) n++;
        end
        checks++;
        if (n != 9) begin errors++; $display("FAIL bp_accepted got=%0d required=9", n); end
        checks++;
        if (IN_READY[0] !== 1'b0) begin errors++; $display("FAIL bp_full_ready got=%b required=0", IN_READY[0]); end
        checks++;
        if (held_bad || OUT_VALID !== 1'b1 || OUT_DATA !== 64'd0) begin
            errors++;
            $display("FAIL bp_hold got=%b/%h required=1/0 stable", OUT_VALID, OUT_DATA);
        end
        @(posedge CLK); #1;
        IN_VALID = '0;
        OUT_READY = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge CLK);
            if (OUT_VALID) drained++;
            else if (exp_q[0].size() == 0) break;
        end
        checks++;
        if (drained != 9 || exp_q[0].size() != 0) begin
            errors++;
            $display("FAIL bp_drain got=%0d left=%0d required=9 left=0", drained, exp_q[0].size());
        end
    endtask

    task automatic test_reset_mid();
        int outs = 0;
        reset_dut();
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK); #1;
            IN_VALID = 4'b0010;
            IN_DATA[64 +: 64] = 64'(100 + i);
        end
        @(posedge CLK); #1;
        IN_VALID = '0;
        @(negedge CLK);
        checks++;
        if (OUT_VALID !== 1'b1) begin errors++; $display("FAIL mid_pre got=%b required=1", OUT_VALID); end
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        @(negedge CLK);
        checks++;
        if (OUT_VALID !== 1'b0 || IN_READY !== 4'b1111) begin
            errors++;
            $display("FAIL mid_flush got=%b/%b required=0/1111", OUT_VALID, IN_READY);
        end
        @(posedge CLK); #1;
        IN_VALID = 4'b1001;
        IN_DATA[0 +: 64]   = 64'hA0;
        IN_DATA[192 +: 64] = 64'hA3;
        OUT_READY = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = '0;
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (OUT_VALID !== 1'b1 || OUT_CHAN !== 2'd0) begin
            errors++;
            $display("FAIL mid_ptr got=%b/%0d required=1/0", OUT_VALID, OUT_CHAN);
        end
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (OUT_VALID) outs++;
            @(negedge CLK);
        end
        checks++;
        if (outs != 2) begin errors++; $display("FAIL mid_count got=%0d required=2", outs); end
    endtask

    task automatic test_back_to_back();
        int seq = 0;
        bit done = 0;
        reset_dut();
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(posedge CLK); #1;
            IN_VALID = 4'($urandom);
            OUT_READY = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < 4; c++) begin
                IN_DATA[c*64 +: 64] = (64'(c) << 32) | 64'(seq);
                seq++;
            end
        end
        @(posedge CLK); #1;
        IN_VALID = '0;
        OUT_READY = 1'b1;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            @(negedge CLK);
            done = !OUT_VALID && exp_q[0].size() == 0 && exp_q[1].size() == 0 &&
                   exp_q[2].size() == 0 && exp_q[3].size() == 0;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL b2b_drain left=%0d/%0d/%0d/%0d required=0", exp_q[0].size(),
                     exp_q[1].size(), exp_q[2].size(), exp_q[3].size());
        end
    endtask

`ifdef STREAM_AGG_STATS_EN
    task automatic test_stats();
        reset_dut();
        OUT_READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            IN_VALID = (i < 2) ? 4'b1010 : 4'b0010;
            IN_DATA[64 +: 64]  = 64'(200 + i);
            IN_DATA[192 +: 64] = 64'(300 + i);
        end
        @(posedge CLK); #1;
        IN_VALID = '0;
        repeat (10) @(negedge CLK);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (STAT_CNT[c*32 +: 32] !== ((c == 1) ? 32'd3 : (c == 3) ? 32'd2 : 32'd0)) begin
                errors++;
                $display("FAIL stat_cnt ch=%0d got=%0d", c, STAT_CNT[c*32 +: 32]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_latency();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
`ifdef STREAM_AGG_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout reached got=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
